// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_pkg: shared FSM state and frame-result types plus key-code width helper.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} kp_state_t;
    typedef enum logic [1:0] {NONE, ONE, MULTI} frame_res_t;

    function automatic int code_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_tick_gen.sv
// scan_tick_gen: prescaler emitting a one-cycle tick every P clocks.
module scan_tick_gen #(
    parameter int P = 4
) (
    input  logic clk,
    input  logic btnres,
    output logic o_tick
);

    localparam int W = $clog2(P);

    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == W'(P - 1));

    always_ff @(posedge clk) begin
        if (!btnres)
            r_cnt <= '0;
        else
            r_cnt <= o_tick ? '0 : r_cnt + W'(1);
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row-scanning keypad controller with frame debounce and n-key lockout.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe a held key after REPEAT_DELAY, then every REPEAT_RATE frames.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int CLK_HZ          = 50000000,
    parameter int SCAN_HZ         = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 250,
    parameter int REPEAT_RATE     = 50,
    localparam int CW             = code_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            btnres,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] fil,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            multi_key
);

    localparam int RW   = $clog2(ROWS);
    localparam int CLW  = $clog2(COLS);
    localparam int CNTW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [COLS-1:0] r_col_s1, r_col_s2;
    logic [RW-1:0]   r_row;
    logic [1:0]      r_hits, w_hits, w_row_hits;
    logic [CW-1:0]   r_first, w_first, r_cand, w_cand_nx;
    logic [CLW-1:0]  w_low_col;
    logic [CNTW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    kp_state_t       r_state, w_state_nx;
    frame_res_t      w_res;
    logic            w_tick, w_frame_end, w_accept, w_release, w_repeat;

    scan_tick_gen #(.P(CLK_HZ / SCAN_HZ)) u_tick (
        .clk    (clk),
        .btnres (btnres),
        .o_tick (w_tick)
    );

    assign fil         = ~(ROWS'(1) << r_row);
    assign w_frame_end = w_tick && (r_row == RW'(ROWS - 1));

    // Downward scan leaves the lowest pressed column as the final assignment.
    always_comb begin
        w_row_hits = '0;
        w_low_col  = '0;
        for (int i = COLS - 1; i >= 0; i--)
            if (!r_col_s2[i]) begin
                w_low_col  = CLW'(i);
                w_row_hits = (w_row_hits == 2'd0) ? 2'd1 : 2'd2;
            end
    end

    assign w_hits  = (r_hits == 2'd0) ? w_row_hits : (w_row_hits == 2'd0) ? r_hits : 2'd2;
    assign w_first = (r_hits == 2'd0 && w_row_hits != 2'd0) ?
                     CW'(int'(r_row) * COLS + int'(w_low_col)) : r_first;
    assign w_res   = (w_hits == 2'd0) ? NONE : (w_hits == 2'd1) ? ONE : MULTI;

    always_ff @(posedge clk) begin
        if (!btnres) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
            r_row    <= '0;
            r_hits   <= '0;
            r_first  <= '0;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
            if (w_tick) begin
                r_row   <= w_frame_end ? '0 : r_row + RW'(1);
                r_hits  <= w_frame_end ? '0 : w_hits;
                r_first <= w_frame_end ? '0 : w_first;
            end
        end
    end

    assign w_cnt_inc = r_cnt + CNTW'(1);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        if (w_frame_end)
            case (r_state)
                IDLE:
                    if (w_res == ONE) begin
                        w_cand_nx  = w_first;
                        w_cnt_nx   = CNTW'(1);
                        w_accept   = (DEBOUNCE_FRAMES == 1);
                        w_state_nx = w_accept ? PRESSED : DEB_PRESS;
                    end
                DEB_PRESS:
                    if (w_res == ONE && w_first == r_cand) begin
                        w_cnt_nx   = w_cnt_inc;
                        w_accept   = (w_cnt_inc == CNTW'(DEBOUNCE_FRAMES));
                        w_state_nx = w_accept ? PRESSED : DEB_PRESS;
                    end else if (w_res == ONE) begin
                        w_cand_nx = w_first;
                        w_cnt_nx  = CNTW'(1);
                    end else begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end
                PRESSED:
                    if (w_res == NONE) begin
                        w_cnt_nx   = CNTW'(1);
                        w_release  = (DEBOUNCE_FRAMES == 1);
                        w_state_nx = w_release ? IDLE : DEB_RELEASE;
                    end
                DEB_RELEASE:
                    if (w_res == NONE) begin
                        w_cnt_nx   = w_cnt_inc;
                        w_release  = (w_cnt_inc == CNTW'(DEBOUNCE_FRAMES));
                        w_state_nx = w_release ? IDLE : DEB_RELEASE;
                    end else
                        w_state_nx = PRESSED;
                default: w_state_nx = IDLE;
            endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int PW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);

    logic [PW-1:0] r_rep, w_rep_inc;
    logic          r_rep_on, w_held_frame;

    // Only frames that end in PRESSED with a hit count as held time.
    assign w_held_frame = w_frame_end && r_state == PRESSED && w_res != NONE;
    assign w_rep_inc    = r_rep + PW'(1);
    assign w_repeat     = w_held_frame &&
                          w_rep_inc == (r_rep_on ? PW'(REPEAT_RATE) : PW'(REPEAT_DELAY));

    always_ff @(posedge clk) begin
        if (!btnres || w_release || w_accept) begin
            r_rep    <= '0;
            r_rep_on <= 1'b0;
        end else if (w_repeat) begin
            r_rep    <= '0;
            r_rep_on <= 1'b1;
        end else if (w_held_frame)
            r_rep <= w_rep_inc;
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!btnres) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cand    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_cand    <= w_cand_nx;
            key_valid <= w_accept || w_repeat;
            if (w_accept)
                key_code <= w_cand_nx;
            if (w_accept)
                key_held <= 1'b1;
            else if (w_release)
                key_held <= 1'b0;
            if (w_frame_end)
                multi_key <= (w_res == MULTI);
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized and directed frame-level checks of keypad_scan_ctrl against a rule model.
module tb_keypad_scan_ctrl;

    localparam int DEB    = 4;
    localparam int RDELAY = 8;
    localparam int RRATE  = 2;

    logic        clk = 1'b0;
    logic        btnres = 1'b0;
    logic [3:0]  col, fil, key_code;
    logic        key_valid, key_held, multi_key;
    logic [15:0] keys = '0;

    int tests = 0, fails = 0, frame_no = 0;
    int m_mode, m_cnt, m_cand, m_code, m_held, m_rep, m_rep_on, e_strobe, e_multi;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .ROWS(4), .COLS(4), .CLK_HZ(400), .SCAN_HZ(100),
        .DEBOUNCE_FRAMES(DEB), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk       (clk),
        .btnres    (btnres),
        .col       (col),
        .fil       (fil),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    // Passive keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !fil[r]) col[c] = 1'b0;
    end

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_cand = 0; m_code = 0; m_held = 0; m_rep = 0; m_rep_on = 0;
    endtask

    // Frame-level rules: 0=idle 1=debouncing press 2=pressed 3=debouncing release.
    task automatic model_step(input logic [15:0] k);
        int n, c;
        n = $countones(k);
        c = 0;
        for (int i = 15; i >= 0; i--) if (k[i]) c = i;
        e_strobe = 0;
        e_multi  = (n >= 2);
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_mode == 2 && n != 0) begin
            m_rep++;
            if (m_rep == (m_rep_on != 0 ? RRATE : RDELAY)) begin
                e_strobe = 1; m_rep = 0; m_rep_on = 1;
            end
        end
`endif
        case (m_mode)
            0: if (n == 1) begin m_cand = c; m_cnt = 1; m_mode = 1; end
            1: if (n == 1 && c == m_cand) m_cnt++;
               else if (n == 1) begin m_cand = c; m_cnt = 1; end
               else m_mode = 0;
            2: if (n == 0) begin m_mode = 3; m_cnt = 1; end
            default: if (n == 0) m_cnt++; else m_mode = 2;
        endcase
        if (m_mode == 1 && m_cnt >= DEB) begin
            m_mode = 2; m_code = m_cand; m_held = 1; e_strobe = 1; m_rep = 0; m_rep_on = 0;
        end
        if (m_mode == 3 && m_cnt >= DEB) begin
            m_mode = 0; m_held = 0; m_rep = 0; m_rep_on = 0;
        end
    endtask

    task automatic do_reset();
        btnres = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (fil !== 4'b1110) begin
            fails++; $display("FAIL reset_fil: got %b want 1110", fil);
        end
        tests++;
        if ({key_valid, key_held, multi_key, key_code} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b held=%b multi=%b code=%0d want all 0",
                     key_valid, key_held, multi_key, key_code);
        end
        btnres = 1'b1;
        model_reset();
    endtask

    // One 16-cycle frame with a steady key set; starts just after a frame boundary.
    task automatic run_frame(input logic [15:0] k);
        int extra, badfil;
        logic [3:0] efil;
        extra = 0; badfil = 0;
        keys = k;
        frame_no++;
        model_step(k);
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk);
            #1;
            efil = ~(4'b0001 << ((j / 4) % 4));
            if (fil !== efil) badfil++;
            if (j < 16 && key_valid !== 1'b0) extra++;
        end
        tests++;
        if (badfil != 0) begin
            fails++; $display("FAIL frame %0d fil_sequence: %0d wrong cycles, want 0", frame_no, badfil);
        end
        tests++;
        if (extra != 0) begin
            fails++; $display("FAIL frame %0d stray_strobe: %0d mid-frame key_valid cycles, want 0", frame_no, extra);
        end
        tests++;
        if (key_valid !== (e_strobe != 0)) begin
            fails++; $display("FAIL frame %0d key_valid: got %b want %0d", frame_no, key_valid, e_strobe);
        end
        tests++;
        if (key_held !== (m_held != 0)) begin
            fails++; $display("FAIL frame %0d key_held: got %b want %0d", frame_no, key_held, m_held);
        end
        tests++;
        if (key_code !== 4'(m_code)) begin
            fails++; $display("FAIL frame %0d key_code: got %0d want %0d", frame_no, key_code, m_code);
        end
        tests++;
        if (multi_key !== (e_multi != 0)) begin
            fails++; $display("FAIL frame %0d multi_key: got %b want %0d", frame_no, multi_key, e_multi);
        end
    endtask

    task automatic test_reset();
        do_reset();
        run_frame(16'h0000);
    endtask

    task automatic test_clean_press();
        do_reset();
        repeat (6) run_frame(16'h0200);
        tests++;
        if (key_code !== 4'd9) begin
            fails++; $display("FAIL clean_press_code: got %0d want 9", key_code);
        end
        repeat (5) run_frame(16'h0000);
    endtask

    task automatic test_bounce();
        do_reset();
        run_frame(16'h0200); run_frame(16'h0200); run_frame(16'h0000);
        repeat (4) run_frame(16'h0200);
        repeat (5) run_frame(16'h0000);
    endtask

    task automatic test_multi_lockout();
        do_reset();
        repeat (4) run_frame(16'h0020);
        repeat (2) run_frame(16'h0420);
        tests++;
        if (key_code !== 4'd5) begin
            fails++; $display("FAIL lockout_code: got %0d want 5", key_code);
        end
        repeat (4) run_frame(16'h0000);
        repeat (4) run_frame(16'h0400);
        repeat (4) run_frame(16'h0000);
    endtask

    task automatic test_reset_mid_debounce();
        int stray;
        stray = 0;
        do_reset();
        repeat (3) run_frame(16'h0200);
        repeat (8) begin
            @(posedge clk);
            #1;
            if (key_valid !== 1'b0) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++; $display("FAIL mid_debounce_strobe: %0d key_valid cycles, want 0", stray);
        end
        do_reset();
        repeat (4) run_frame(16'h0200);
        repeat (4) run_frame(16'h0000);
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        do_reset();
        repeat (18) run_frame(16'h0001);
        run_frame(16'h0000);
        repeat (3) run_frame(16'h0001);
        repeat (6) run_frame(16'h0000);
    endtask
`endif

    task automatic test_random();
        logic [15:0] k;
        k = '0;
        do_reset();
        for (int f = 0; f < 80; f++) begin
            case ($urandom_range(0, 6))
                0: k = '0;
                1: k = 16'(1) << $urandom_range(0, 15);
                2: k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: ;
            endcase
            run_frame(k);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_lockout();
        test_reset_mid_debounce();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
